// File: rtl/palette_arbiter_if.sv
// palette_arbiter_if: groups the requester handshake, palette port and
// response signals of palette_arbiter into a single bundle.
//   slave  : arbiter side (drives ready, palette index, responses, busy)
//   master : environment side (drives requests and the palette colour)
// Signal names keep the arbiter's _in/_out direction suffixes.
interface palette_arbiter_if #(
  parameter int N_REQ   = 4,
  parameter int IDX_W   = 4,
  parameter int COLOR_W = 24
);
  logic [N_REQ-1:0]       req_valid_in;
  logic [N_REQ*IDX_W-1:0] req_idx_in;
  logic [N_REQ-1:0]       req_ready_out;
  logic [IDX_W-1:0]       pal_idx_out;
  logic [COLOR_W-1:0]     pal_color_in;
  logic [N_REQ-1:0]       rsp_valid_out;
  logic [COLOR_W-1:0]     rsp_color_out;
  logic                   busy_out;

  modport slave (
    input  req_valid_in, req_idx_in, pal_color_in,
    output req_ready_out, pal_idx_out, rsp_valid_out, rsp_color_out, busy_out
  );

  modport master (
    output req_valid_in, req_idx_in, pal_color_in,
    input  req_ready_out, pal_idx_out, rsp_valid_out, rsp_color_out, busy_out
  );
endinterface

// File: rtl/palette_arbiter.sv
// palette_arbiter: shares one registered-read palette lookup port among
// N_REQ pixel sources. One valid/ready handshake per cycle, round-robin
// with a bounded burst per grantee. Each handshake registers its index to
// the palette and pushes a {valid, id} tag through a 1+PAL_LAT shift
// register; when the tag leaves, the palette colour is steered back to the
// issuing requester. Responses return in issue order, cannot be stalled.
//
// Ports:
//   clk_in  - system clock
//   rst_in  - asynchronous active-low reset (also forces req_ready_out = 0)
//   bus     - palette_arbiter_if.slave:
//     req_valid_in/req_idx_in  per-requester request and index
//     req_ready_out            one-hot-or-zero grant
//     pal_idx_out              registered index to the palette
//     pal_color_in             palette colour, PAL_LAT cycles after index
//     rsp_valid_out            one-hot-or-zero response strobe
//     rsp_color_out            returned colour (0 when no response)
//     busy_out                 lookup in flight or grant active
//
// Build option: define PALETTE_ARB_FIXED_PRI_EN for fixed priority
// (lowest-index valid requester always wins; burst state is not built).
module palette_arbiter #(
  parameter int N_REQ   = 4,
  parameter int IDX_W   = 4,
  parameter int COLOR_W = 24,
  parameter int PAL_LAT = 1,
  parameter int BURST   = 4
) (
  input logic               clk_in,
  input logic               rst_in,
  palette_arbiter_if.slave  bus
);

  localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int DEPTH = 1 + PAL_LAT;

  logic             pick_vld;
  logic [ID_W-1:0]  sel_id;
  logic [IDX_W-1:0] sel_idx;
  logic             hs;
  logic [N_REQ-1:0] grant;

  logic [IDX_W-1:0] pal_idx_q, pal_idx_d;
  logic [DEPTH-1:0] tag_vld_q;
  logic [ID_W-1:0]  tag_id_q [DEPTH];

`ifdef PALETTE_ARB_FIXED_PRI_EN
  // Downward scan so the lowest-index valid requester is the last writer.
  always_comb begin
    pick_vld = 1'b0;
    sel_id   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (bus.req_valid_in[i]) begin
        pick_vld = 1'b1;
        sel_id   = ID_W'(i);
      end
    end
  end
`else
  localparam int CNT_W = $clog2(BURST + 1);

  logic [ID_W-1:0]  holder_q, holder_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  function automatic logic [ID_W-1:0] wrap_id(input logic [ID_W-1:0] base,
                                               input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return ID_W'(s);
  endfunction

  // cnt == 0 means no burst in progress, so the holder only keeps the
  // grant while a burst it won is still open and under the limit.
  always_comb begin
    pick_vld = 1'b0;
    sel_id   = holder_q;
    holder_d = holder_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    if (bus.req_valid_in[holder_q] && (cnt_q != '0) && (cnt_q < CNT_W'(BURST))) begin
      pick_vld = 1'b1;
      cnt_d    = cnt_q + CNT_W'(1);
    end else begin
      // Downward scan: the smallest offset from ptr is the last writer.
      for (int j = N_REQ - 1; j >= 0; j--) begin
        if (bus.req_valid_in[wrap_id(ptr_q, j)]) begin
          pick_vld = 1'b1;
          sel_id   = wrap_id(ptr_q, j);
        end
      end
      if (pick_vld) begin
        holder_d = sel_id;
        cnt_d    = CNT_W'(1);
        ptr_d    = wrap_id(sel_id, 1);
      end else begin
        cnt_d    = '0;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      holder_q <= '0;
      cnt_q    <= '0;
      ptr_q    <= '0;
    end else begin
      holder_q <= holder_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
    end
  end
`endif

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (sel_id == ID_W'(i)) sel_idx = bus.req_idx_in[i*IDX_W +: IDX_W];
    end
  end

  // Every grant is a handshake since a grant only goes to a valid requester;
  // gating with rst_in keeps ready low throughout reset.
  assign hs = pick_vld & rst_in;

  always_comb begin
    grant = '0;
    if (hs) grant[sel_id] = 1'b1;
  end

  assign pal_idx_d = hs ? sel_idx : pal_idx_q;

  // Stage 0 register boundary: palette index and tag pipeline
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      pal_idx_q <= '0;
      tag_vld_q <= '0;
    end else begin
      pal_idx_q <= pal_idx_d;
      tag_vld_q <= {tag_vld_q[DEPTH-2:0], hs};
    end
  end

  // Tag ids are qualified by tag_vld_q, so they need no reset.
  always_ff @(posedge clk_in) begin
    tag_id_q[0] <= sel_id;
    for (int k = 1; k < DEPTH; k++) tag_id_q[k] <= tag_id_q[k-1];
  end

  // The last tag stage lines up with the palette's registered output.
  always_comb begin
    bus.rsp_valid_out = '0;
    bus.rsp_color_out = '0;
    if (tag_vld_q[DEPTH-1]) begin
      bus.rsp_valid_out[tag_id_q[DEPTH-1]] = 1'b1;
      bus.rsp_color_out                    = bus.pal_color_in;
    end
  end

  assign bus.req_ready_out = grant;
  assign bus.pal_idx_out   = pal_idx_q;
  assign bus.busy_out      = (|tag_vld_q) | (|grant);

endmodule

// File: tb/tb_palette_arbiter.sv
module tb_palette_arbiter;
  localparam int N_REQ   = 4;
  localparam int IDX_W   = 4;
  localparam int COLOR_W = 24;
  localparam int PAL_LAT = 1;
  localparam int BURST   = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  palette_arbiter_if #(.N_REQ(N_REQ), .IDX_W(IDX_W), .COLOR_W(COLOR_W)) bus ();

  palette_arbiter #(
    .N_REQ(N_REQ), .IDX_W(IDX_W), .COLOR_W(COLOR_W),
    .PAL_LAT(PAL_LAT), .BURST(BURST)
  ) dut (
    .clk_in (clk),
    .rst_in (rst_n),
    .bus    (bus)
  );

  logic [N_REQ-1:0]       drv_v  = '0;
  logic [N_REQ*IDX_W-1:0] drv_ix = '0;
  assign bus.req_valid_in = drv_v;
  assign bus.req_idx_in   = drv_ix;

  // Palette contents: entry 3 is the reference colour, others derived.
  function automatic logic [COLOR_W-1:0] lut(input logic [IDX_W-1:0] i);
    if (i == IDX_W'(3)) return 24'hbe2633;
    return COLOR_W'((32'(i) + 32'd1) * 32'h0013a5c7);
  endfunction

  // Palette with registered read of PAL_LAT cycles.
  logic [COLOR_W-1:0] pal_pipe [PAL_LAT];
  always @(posedge clk) begin
    pal_pipe[0] <= lut(bus.pal_idx_out);
    for (int k = 1; k < PAL_LAT; k++) pal_pipe[k] <= pal_pipe[k-1];
  end
  assign bus.pal_color_in = pal_pipe[PAL_LAT-1];

  // Reference model state
  typedef struct {
    int                 due;
    int                 id;
    logic [COLOR_W-1:0] color;
  } rsp_t;
  rsp_t             exp_q[$];
  int               m_holder, m_cnt, m_ptr;
  logic [IDX_W-1:0] m_pal_idx;
  logic [N_REQ-1:0] last_grant;
  int               cyc;
  int               n_chk, n_pass;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic void model_reset();
    exp_q.delete();
    m_holder  = 0;
    m_cnt     = 0;
    m_ptr     = 0;
    m_pal_idx = '0;
  endfunction

  function automatic int model_pick(input logic [N_REQ-1:0] v, output bit kept);
    kept = 1'b0;
`ifdef PALETTE_ARB_FIXED_PRI_EN
    for (int i = 0; i < N_REQ; i++) if (v[i]) return i;
    return -1;
`else
    if (v[m_holder] && m_cnt > 0 && m_cnt < BURST) begin
      kept = 1'b1;
      return m_holder;
    end
    for (int j = 0; j < N_REQ; j++) if (v[(m_ptr + j) % N_REQ]) return (m_ptr + j) % N_REQ;
    return -1;
`endif
  endfunction

  function automatic void model_advance(input int pick, input bit kept);
`ifndef PALETTE_ARB_FIXED_PRI_EN
    if (pick < 0) m_cnt = 0;
    else if (kept) m_cnt = m_cnt + 1;
    else begin
      m_holder = pick;
      m_cnt    = 1;
      m_ptr    = (pick + 1) % N_REQ;
    end
`endif
  endfunction

  // One clock: check outputs at the falling edge, advance the model, then
  // return 1 time unit after the next rising edge.
  task automatic step();
    int                 pick;
    bit                 kept;
    logic [N_REQ-1:0]   eg, erv;
    logic [COLOR_W-1:0] ec;
    logic               eb;
    logic [IDX_W-1:0]   ix;
    @(negedge clk);
    if (!rst_n) model_reset();
    pick = -1;
    kept = 1'b0;
    eg   = '0;
    if (rst_n) begin
      pick = model_pick(drv_v, kept);
      if (pick >= 0) eg[pick] = 1'b1;
    end
    eb  = (exp_q.size() != 0) || (eg != '0);
    erv = '0;
    ec  = '0;
    if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
      erv[exp_q[0].id] = 1'b1;
      ec = exp_q[0].color;
      void'(exp_q.pop_front());
    end
    chk_eq("req_ready", 32'(bus.req_ready_out), 32'(eg));
    chk_eq("rsp_valid", 32'(bus.rsp_valid_out), 32'(erv));
    chk_eq("rsp_color", 32'(bus.rsp_color_out), 32'(ec));
    chk_eq("busy", 32'(bus.busy_out), 32'(eb));
    chk_eq("pal_idx", 32'(bus.pal_idx_out), 32'(m_pal_idx));
    if (rst_n) begin
      if (pick >= 0) begin
        ix = drv_ix[pick*IDX_W +: IDX_W];
        exp_q.push_back('{cyc + 1 + PAL_LAT, pick, lut(ix)});
        m_pal_idx = ix;
      end
      model_advance(pick, kept);
    end
    last_grant = eg;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Requests stay stable until their handshake; afterwards each requester
  // re-raises with a fresh random index with probability pct (if in mask).
  task automatic drive_rand(input int pct, input logic [N_REQ-1:0] mask);
    for (int k = 0; k < N_REQ; k++) begin
      if (drv_v[k] && !last_grant[k]) continue;
      if (mask[k] && $urandom_range(0, 99) < pct) begin
        drv_v[k] = 1'b1;
        drv_ix[k*IDX_W +: IDX_W] = IDX_W'($urandom);
      end else begin
        drv_v[k] = 1'b0;
      end
    end
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) step();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [N_REQ-1:0] exp_g;
    n_chk = 0;
    n_pass = 0;
    cyc = 0;
    last_grant = '0;
    model_reset();
    #1;

    // Reset, then idle
    do_reset(3);
    repeat (4) step();

    // Requester 2 alone, index 3
    drv_v = 4'b0100;
    drv_ix[2*IDX_W +: IDX_W] = 4'h3;
    step();
    chk_eq("single_grant", 32'(last_grant), 32'h4);
    drv_v = '0;
    chk_eq("single_pal_idx", 32'(bus.pal_idx_out), 32'h3);
    step();
    chk_eq("single_rsp_valid", 32'(bus.rsp_valid_out), 32'h4);
    chk_eq("single_rsp_color", 32'(bus.rsp_color_out), 32'hbe2633);
    repeat (2) step();

    // All requesters continuously valid from a fresh reset
    do_reset(2);
    for (int i = 0; i < 20; i++) begin
      drive_rand(100, '1);
      step();
      exp_g = '0;
`ifdef PALETTE_ARB_FIXED_PRI_EN
      exp_g[0] = 1'b1;
`else
      exp_g[(i / BURST) % N_REQ] = 1'b1;
`endif
      chk_eq("rr_sequence", 32'(last_grant), 32'(exp_g));
    end

    // Reset with lookups in flight; nothing may come back afterwards
    do_reset(2);
    drv_v = '0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_eq("no_rsp_after_rst", 32'(bus.rsp_valid_out), 32'h0);
    end

    // Holder 1 drops after two handshakes while 3 is waiting
    drv_v = 4'b1010;
    drv_ix[1*IDX_W +: IDX_W] = 4'h7;
    drv_ix[3*IDX_W +: IDX_W] = 4'h9;
    step();
    chk_eq("drop_first", 32'(last_grant), 32'h2);
    drv_ix[1*IDX_W +: IDX_W] = 4'ha;
    step();
    chk_eq("drop_second", 32'(last_grant), 32'h2);
    drv_v = 4'b1000;
    step();
    chk_eq("drop_moves_to_3", 32'(last_grant), 32'h8);
    drv_v = 4'b0011;
    step();
    chk_eq("search_from_0", 32'(last_grant), 32'h1);
    drv_v = '0;
    repeat (3) step();

    // Single requester continuously valid across burst boundaries
    for (int i = 0; i < 3 * BURST; i++) begin
      drive_rand(100, 4'b0010);
      step();
      chk_eq("lone_keeps_grant", 32'(last_grant), 32'h2);
    end

    // Randomized traffic at several load levels, with a mid-run reset
    for (int seg = 0; seg < 6; seg++) begin
      for (int i = 0; i < 60; i++) begin
        drive_rand((seg % 3) * 35 + 20, '1);
        step();
      end
      if (seg == 2) do_reset(1);
    end
    drv_v = '0;
    repeat (4) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/palette_arbiter.md
# palette_arbiter

Shares the single palette lookup port (4-bit index in, 24-bit colour out, registered read) among several pixel sources such as background, sprite and HUD layers. Requesters present indices with a valid/ready handshake. The arbiter grants one per cycle, round-robin with a bounded burst. It drives the palette index and tracks in-flight lookups through a tag pipeline matched to the palette latency, then returns each colour to the requester that issued it.

## Interface
- N_REQ, 4: number of requesters, 2..8
- IDX_W, 4: palette index width
- COLOR_W, 24: colour width
- PAL_LAT, 1: palette read latency in cycles, 1..3
- BURST, 4: max consecutive handshakes per grant, 1..16
- clk_in  input  1  system clock
- rst_in  input  1  asynchronous, active-low reset
- req_valid_in  input  N_REQ  per-requester lookup request
- req_idx_in  input  N_REQ*IDX_W  per-requester index, requester k at bits [k*IDX_W +: IDX_W]
- req_ready_out  output  N_REQ  one-hot-or-zero grant; handshake = valid & ready
- pal_idx_out  output  IDX_W  registered index to palette
- pal_color_in  input  COLOR_W  palette colour, valid PAL_LAT cycles after pal_idx_out
- rsp_valid_out  output  N_REQ  one-hot-or-zero response strobe
- rsp_color_out  output  COLOR_W  returned colour, qualified by rsp_valid_out
- busy_out  output  1  any lookup in flight or grant held

## Operation
- Grant is computed combinationally from req_valid_in and the holder/count state.
  - req_valid_in must not depend on req_ready_out.
  - Once a request is raised, its valid and index stay stable until the handshake.
- State: holder (index of the current grantee), cnt (handshakes in the current burst, 0..BURST), ptr (round-robin start).
- The holder keeps the grant while its valid is 1 and cnt < BURST.
- Otherwise the grant goes to the first valid requester searching from ptr, wrapping modulo N_REQ. ptr is then updated to that requester + 1 modulo N_REQ.
- cnt resets to 1 on a new grant with a handshake and increments on each further handshake by the holder.
- When no requester is valid, req_ready_out = 0 and cnt = 0.
- A holder dropping valid mid-burst ends its burst immediately. Another valid requester may be granted in that same cycle.
- On a handshake:
  - the selected index is registered to pal_idx_out;
  - a tag {valid, requester id} enters a shift register of depth 1 + PAL_LAT.
- Response: when the tag exits the shift register, rsp_valid_out[id] = 1 and rsp_color_out = pal_color_in for one cycle. Responses cannot be backpressured.
- pal_idx_out holds its last value when no handshake occurs.
- busy_out = any tag valid | (req_ready_out != 0).
- Throughput: one lookup per cycle sustained. Responses return in issue order.

## Timing
- Reset (rst_in = 0, asynchronous): pal_idx_out = 0, all tags invalid, rsp_valid_out = 0, rsp_color_out = 0, holder = 0, cnt = 0, ptr = 0, busy_out = 0.
- req_ready_out is 0 while in reset.
- Handshake at cycle T:
  - pal_idx_out is updated at T+1;
  - rsp_valid_out is asserted at T+1+PAL_LAT (T+2 for the default).
- Reset asserted mid-operation discards all in-flight tags. No response is emitted for them, and post-reset operation starts from ptr = 0.
- Simultaneous requests: exactly one grant per cycle, never two bits of req_ready_out set.
- BURST = 1 degenerates to pure per-cycle round-robin.
- A single requester that is continuously valid keeps the grant indefinitely. Its burst restarts with cnt = 1 because it is the only candidate.

## Configuration
- PALETTE_ARB_FIXED_PRI_EN defined:
  - fixed priority: the lowest-index valid requester is granted every cycle;
  - BURST, holder, cnt and ptr are unused and tied to 0.
  - Requester 0 (background) can starve others; this is intended for the HUD-over-background debug mode.
- PALETTE_ARB_FIXED_PRI_EN undefined: round-robin with burst as described in Operation.

## Test plan
- Reset, then all requesters idle -> req_ready_out = 0, rsp_valid_out = 0, busy_out = 0.
- Requester 2 only, index 4'h3, PAL_LAT = 1:
  - handshake at T;
  - pal_idx_out = 3 at T+1;
  - rsp_valid_out = 4'b0100 at T+2 with colour 24'hbe2633.
- All four valid for 20 cycles, BURST = 4 -> grants 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0... and responses arrive in the same order, 2 cycles later.
- Holder 1 drops valid after 2 handshakes while 3 is valid -> the grant moves to 3 in the same cycle with no idle cycle, and the next round-robin search starts at 0.
- Assert rst_in = 0 with 2 lookups in flight -> no rsp_valid_out pulses for those lookups after reset release.
- With PALETTE_ARB_FIXED_PRI_EN defined and requesters 0 and 3 both valid continuously -> requester 0 is granted every cycle and requester 3 is never granted.
